game_sequencer: RTL

Frame-synchronous game controller that sequences the ball/bar drawing datapath of the HDMI sample. It debounces the push switch, detects frame starts, and runs a game state machine (attract, serve, play, miss, game over). It tracks lives, score and ball speed level from hit/miss events reported by the ball logic. Its outputs gate ball motion and issue serve/restart pulses to the draw engine.

---
 rtl/game_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer
// Frame-synchronous controller for the HDMI ball/bar game. It detects frame
// starts from the raw vsync, debounces the push switch once per frame, and runs
// the game state machine (IDLE, SERVE, PLAY, MISS, OVER). From the ball logic's
// hit/miss pulses it keeps lives, score and ball speed, and it drives the
// ball motion enable and serve pulse towards the draw engine.
//
// Ports
//   clk          system clock
//   reset_n      synchronous reset, active low
//   in_vsync     raw vsync from the timing generator
//   push_sw      raw push switch (asynchronous, synchronised here)
//   ev_hit       one-cycle pulse, ball reflected off the bar
//   ev_miss      one-cycle pulse, ball passed the bottom edge
//   frame_start  one-cycle pulse at each vsync 1->0 edge (registered)
//   sw_level     debounced switch level
//   sw_press     one-cycle pulse on debounced 0->1
//   ball_run     ball motion enable (high in PLAY)
//   ball_serve   one-cycle pulse, re-centre the ball
//   ball_speed   current speed level
//   lives        remaining lives
//   score        saturating hit count
//   state        IDLE=0 SERVE=1 PLAY=2 MISS=3 OVER=4 (debug/state visibility)
//   game_over    high while in OVER
//
// Handshake note: there is no valid/ready flow here. ev_hit, ev_miss,
// frame_start, sw_press and ball_serve are single-cycle strobes; a strobe is
// consumed on the clock edge that ends the cycle it is high in, and it is
// judged against the state that is current during that cycle.
module game_sequencer #(
    parameter int LIVES           = 3,
    parameter int SERVE_FRAMES    = 60,
    parameter int MISS_FRAMES     = 90,
    parameter int OVER_FRAMES     = 180,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int HITS_PER_LEVEL  = 4,
    parameter int SPEED_INIT      = 2,
    parameter int SPEED_MAX       = 6,
    parameter int SPEED_WIDTH     = 4,
    parameter int SCORE_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_vsync,
    input  logic                   push_sw,
    input  logic                   ev_hit,
    input  logic                   ev_miss,
    output logic                   frame_start,
    output logic                   sw_level,
    output logic                   sw_press,
    output logic                   ball_run,
    output logic                   ball_serve,
    output logic [SPEED_WIDTH-1:0] ball_speed,
    output logic [2:0]             lives,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [2:0]             state,
    output logic                   game_over
);

    localparam int TMAX_A = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int TMAX   = (TMAX_A > OVER_FRAMES) ? TMAX_A : OVER_FRAMES;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int DW     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int HW     = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [TW-1:0] T_SERVE = TW'(SERVE_FRAMES - 1);
    localparam logic [TW-1:0] T_MISS  = TW'(MISS_FRAMES - 1);
    localparam logic [TW-1:0] T_OVER  = TW'(OVER_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t                 st, st_n;
    logic [TW-1:0]          timer, timer_n;
    logic [HW-1:0]          hit_cnt, hit_n;
    logic [2:0]             lives_n;
    logic [SCORE_WIDTH-1:0] score_n;
    logic [SPEED_WIDTH-1:0] speed_n;
    logic                   serve_n;
    logic                   timer_exp;

    logic [1:0]    sync_q;
    logic          prev_vsync;
    logic [DW-1:0] deb_cnt;

    assign state = st;

    // Frame detection and switch debounce. The debounced level only moves
    // after DEBOUNCE_FRAMES consecutive frame samples disagree with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q      <= 2'b00;
            prev_vsync  <= 1'b0;
            frame_start <= 1'b0;
            sw_level    <= 1'b0;
            sw_press    <= 1'b0;
            deb_cnt     <= '0;
        end else begin
            sync_q      <= {sync_q[0], push_sw};
            prev_vsync  <= in_vsync;
            frame_start <= prev_vsync & ~in_vsync;
            sw_press    <= 1'b0;
            if (frame_start) begin
                if (sync_q[1] != sw_level) begin
                    if (deb_cnt == DW'(DEBOUNCE_FRAMES - 1)) begin
                        sw_level <= ~sw_level;
                        sw_press <= ~sw_level;
                        deb_cnt  <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end else begin
                    deb_cnt <= '0;
                end
            end
        end
    end

    // Game state register plus the counters it owns. ball_run and game_over
    // are registered from the next state so they line up with 'state'.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st         <= S_IDLE;
            timer      <= '0;
            hit_cnt    <= '0;
            lives      <= 3'd0;
            score      <= '0;
            ball_speed <= SPEED_WIDTH'(SPEED_INIT);
            ball_serve <= 1'b0;
            ball_run   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            st         <= st_n;
            timer      <= timer_n;
            hit_cnt    <= hit_n;
            lives      <= lives_n;
            score      <= score_n;
            ball_speed <= speed_n;
            ball_serve <= serve_n;
            ball_run   <= (st_n == S_PLAY);
            game_over  <= (st_n == S_OVER);
        end
    end

    // Timed states count frames down from N-1; the frame that finds the
    // timer at zero is the N-th and ends the state.
    always_comb begin
        st_n      = st;
        timer_n   = timer;
        hit_n     = hit_cnt;
        lives_n   = lives;
        score_n   = score;
        speed_n   = ball_speed;
        serve_n   = 1'b0;
        timer_exp = frame_start && (timer == '0);

        case (st)
            S_IDLE: begin
                if (sw_press) begin
                    st_n    = S_SERVE;
                    timer_n = T_SERVE;
                    serve_n = 1'b1;
                    lives_n = 3'(LIVES);
                    score_n = '0;
                    speed_n = SPEED_WIDTH'(SPEED_INIT);
                    hit_n   = '0;
                end
            end
            S_SERVE: begin
                if (timer_exp || sw_press) begin
                    st_n = S_PLAY;
                end else if (frame_start) begin
                    timer_n = timer - TW'(1);
                end
            end
            S_PLAY: begin
                // A miss in the same cycle as a hit discards the hit.
                if (ev_miss) begin
                    st_n    = S_MISS;
                    timer_n = T_MISS;
                    if (lives != 3'd0) begin
                        lives_n = lives - 3'd1;
                    end
                end else if (ev_hit) begin
                    if (score != '1) begin
                        score_n = score + SCORE_WIDTH'(1);
                    end
                    if (hit_cnt == HW'(HITS_PER_LEVEL - 1)) begin
                        hit_n = '0;
                        if (ball_speed != SPEED_WIDTH'(SPEED_MAX)) begin
                            speed_n = ball_speed + SPEED_WIDTH'(1);
                        end
                    end else begin
                        hit_n = hit_cnt + HW'(1);
                    end
                end
            end
            S_MISS: begin
                if (timer_exp) begin
                    if (lives == 3'd0) begin
                        st_n    = S_OVER;
                        timer_n = T_OVER;
                    end else begin
                        st_n    = S_SERVE;
                        timer_n = T_SERVE;
                        serve_n = 1'b1;
                    end
                end else if (frame_start) begin
                    timer_n = timer - TW'(1);
                end
            end
            S_OVER: begin
                // Switch presses are ignored here; score stays visible.
                if (timer_exp) begin
                    st_n = S_IDLE;
                end else if (frame_start) begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                st_n = S_IDLE;
            end
        endcase
    end

endmodule
